hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage core: sequences the PC, IF/ID, ID/EX and EX/MEM registers by generating write-enables, flushes and a freeze. Handles load-use stalls of configurable length, taken-branch and jump redirects, and data-memory wait states with a timeout detector. Sits beside the ID stage and drives `CFlush` plus a new write-enable on the ID/EX register.

## Interface
- `LOAD_BUBBLES`, 1: bubbles inserted per load-use hazard (1..3).
- `MEM_TIMEOUT`, 255: consecutive `mem_busy` cycles before `mem_timeout` sets (1..65535).
- `STAT_W`, 32: statistics counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads rt.
- `id_jump` in 1: jump decoded in ID.
- `ex_mem_read` in 1: instruction in EX is a load.
- `ex_rt` in 5: load destination in EX.
- `ex_branch_taken` in 1: branch resolved taken in EX.
- `mem_busy` in 1: data memory not ready in MEM.
- `pc_we`, `ifid_we`, `idex_we` out 1: register write-enables.
- `ifid_flush`, `idex_flush` out 1: load a bubble (effective only when the matching `_we` is 1).
- `exmem_hold` out 1: freeze EX/MEM and MEM/WB.
- `ctrl_state` out 2: FSM state.
- `mem_timeout` out 1: sticky timeout flag.
- `stall_cycles`, `flush_events` out STAT_W: statistics.

## Operation
- FSM states: RUN=0, LOADUSE=1, MEMWAIT=2. Outputs are Mealy (state plus current inputs). Default: all `_we`=1, flushes=0, hold=0.
- Hazard definition: `lu = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`.
- Freeze pattern: all `_we`=0, flushes=0, `exmem_hold`=1.
- RUN priority, first match wins:
  1. `mem_busy`: freeze; wait counter←1; next MEMWAIT.
  2. `ex_branch_taken`: `ifid_flush`=1, `idex_flush`=1, `pc_we`=1; stay RUN.
  3. `lu`: `pc_we`=0, `ifid_we`=0, `idex_flush`=1; bubble counter←LOAD_BUBBLES-1; next LOADUSE if LOAD_BUBBLES>1, else RUN.
  4. `id_jump`: `ifid_flush`=1.
- LOADUSE:
  - If `mem_busy`: freeze; bubble counter holds; stay LOADUSE.
  - Else: same outputs as the RUN load-use row; counter decrements; return to RUN in the cycle the counter equals 1.
  - `ex_branch_taken` and `id_jump` are ignored in LOADUSE, since EX holds a bubble and ID is stalled.
- MEMWAIT:
  - While `mem_busy`: freeze; wait counter increments and saturates at MEM_TIMEOUT; `mem_timeout` sets when the counter reaches MEM_TIMEOUT. The flag clears only on reset.
  - When `mem_busy`=0: evaluate the RUN rules combinationally in that same cycle; next state from RUN rules; wait counter←0.
- `ctrl_state` reflects the registered state.

## Timing
- Zero-cycle combinational path from inputs to enable/flush/hold outputs. Registered state, counters and flags update on the `clk` rising edge.
- Load-use stall costs exactly LOAD_BUBBLES cycles when `mem_busy` is 0. Branch costs 2 flushed slots. Jump costs 1.
- Reset, any time including mid-stall:
  - state→RUN; counters→0; `mem_timeout`→0; stats→0.
  - While `reset`=1: all `_we`=0, flushes=0, `exmem_hold`=0.
- `mem_busy` together with `ex_branch_taken`: freeze wins; the branch is re-evaluated after the wait ends.

## Configuration
- `HAZARD_STATS_EN`:
  - Defined: `stall_cycles` counts cycles with `pc_we`=0 outside reset. `flush_events` counts cycles with `ifid_flush|idex_flush`. Both saturate at all-ones.
  - Undefined: ports remain and are tied to 0; no counter logic is generated.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state encoding (RUN/LOADUSE/MEMWAIT);
  - `REG_ZERO` (5'd0);
  - the freeze and default output bundles as constants.
- Sub-module `load_use_detect`: combinational `lu` comparator, reused by the forwarding unit.

## Test plan
- `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8, LOAD_BUBBLES=2 → `pc_we`/`ifid_we`=0 and `idex_flush`=1 for 2 cycles; `ctrl_state` 0→1→0.
- `ex_rt`=0 with `id_rs`=0 and `ex_mem_read`=1 → no stall, all `_we`=1.
- `ex_branch_taken`=1 together with `lu`=1 → `ifid_flush`=`idex_flush`=1, `pc_we`=1, no stall cycle.
- `mem_busy` high for 3 cycles during LOADUSE → freeze for 3 cycles, then the remaining bubble is completed, then RUN.
- MEM_TIMEOUT=4, `mem_busy` held for 6 cycles → `mem_timeout` rises after the 4th busy cycle and stays 1 after `mem_busy` drops until `reset`.
- `reset` pulsed mid-MEMWAIT → `ctrl_state`=0, `mem_timeout`=0, stats=0 immediately; normal flow resumes on the first edge after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, register-zero constant and output bundles for the
// pipeline hazard controller and the forwarding unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOADUSE = 2'd1,
    ST_MEMWAIT = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_hold;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_DEFAULT = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                         ifid_flush: 1'b0, idex_flush: 1'b0, exmem_hold: 1'b0};
  localparam ctrl_out_t CTRL_FREEZE  = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                         ifid_flush: 1'b0, idex_flush: 1'b0, exmem_hold: 1'b1};
  localparam ctrl_out_t CTRL_LOADUSE = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1,
                                         ifid_flush: 1'b0, idex_flush: 1'b1, exmem_hold: 1'b0};
  localparam ctrl_out_t CTRL_BRANCH  = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                         ifid_flush: 1'b1, idex_flush: 1'b1, exmem_hold: 1'b0};
  localparam ctrl_out_t CTRL_RESET   = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                         ifid_flush: 1'b0, idex_flush: 1'b0, exmem_hold: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Shared with the forwarding unit.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_lu
);

  // Loads to r0 never create a dependency since r0 is hardwired.
  assign o_lu = i_ex_mem_read && (i_ex_rt != REG_ZERO) &&
                ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy enables/flushes for load-use, branch, jump
// and memory-wait hazards. Optional statistics counters under HAZARD_STATS_EN.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned STAT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_hold,
  output logic [1:0]        ctrl_state,
  output logic              mem_timeout,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
);

  localparam logic [15:0] WAIT_MAX = 16'(MEM_TIMEOUT);
  localparam logic [1:0]  BUB_INIT = 2'(LOAD_BUBBLES - 1);

  ctrl_state_t r_state, w_state_nxt;
  logic [1:0]  r_bub, w_bub_nxt;
  logic [15:0] r_wait, w_wait_nxt;
  logic        r_timeout;
  logic        w_lu;
  ctrl_out_t   w_ctrl, w_out;

  load_use_detect u_lu (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (id_uses_rt),
    .o_lu          (w_lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_bub     <= 2'd0;
      r_wait    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bub   <= w_bub_nxt;
      r_wait  <= w_wait_nxt;
      if (w_wait_nxt == WAIT_MAX) r_timeout <= 1'b1;
    end
  end

  // A finished memory wait falls through to the RUN rules in the same cycle.
  always_comb begin
    w_ctrl      = CTRL_DEFAULT;
    w_state_nxt = ST_RUN;
    w_bub_nxt   = r_bub;
    w_wait_nxt  = 16'd0;
    if (mem_busy) begin
      w_ctrl = CTRL_FREEZE;
      case (r_state)
        ST_LOADUSE: w_state_nxt = ST_LOADUSE;
        ST_MEMWAIT: begin
          w_state_nxt = ST_MEMWAIT;
          w_wait_nxt  = (r_wait >= WAIT_MAX) ? WAIT_MAX : r_wait + 16'd1;
        end
        default: begin
          w_state_nxt = ST_MEMWAIT;
          w_wait_nxt  = 16'd1;
        end
      endcase
    end else if (r_state == ST_LOADUSE) begin
      w_ctrl      = CTRL_LOADUSE;
      w_bub_nxt   = r_bub - 2'd1;
      w_state_nxt = (r_bub > 2'd1) ? ST_LOADUSE : ST_RUN;
    end else if (ex_branch_taken) begin
      w_ctrl = CTRL_BRANCH;
    end else if (w_lu) begin
      w_ctrl      = CTRL_LOADUSE;
      w_bub_nxt   = BUB_INIT;
      w_state_nxt = (LOAD_BUBBLES > 1) ? ST_LOADUSE : ST_RUN;
    end else if (id_jump) begin
      w_ctrl.ifid_flush = 1'b1;
    end
  end

  assign w_out       = reset ? CTRL_RESET : w_ctrl;
  assign pc_we       = w_out.pc_we;
  assign ifid_we     = w_out.ifid_we;
  assign idex_we     = w_out.idex_we;
  assign ifid_flush  = w_out.ifid_flush;
  assign idex_flush  = w_out.idex_flush;
  assign exmem_hold  = w_out.exmem_hold;
  assign ctrl_state  = r_state;
  assign mem_timeout = r_timeout;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_out.pc_we && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      if ((w_out.ifid_flush || w_out.idex_flush) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + STAT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int LB  = 2;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, id_jump = 1'b0, ex_mem_read = 1'b0;
  logic        ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic        pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_hold, mem_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles, flush_events;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.LOAD_BUBBLES(LB), .MEM_TIMEOUT(TMO), .STAT_W(32)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .pc_we(pc_we),
    .ifid_we(ifid_we), .idex_we(idex_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_hold(exmem_hold), .ctrl_state(ctrl_state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bubbles still owed, length of the current busy run,
  // whether a memory wait is in progress, and the sticky timeout.
  int     m_bub_left = 0;
  int     m_busy_run = 0;
  bit     m_waiting  = 0;
  bit     m_to       = 0;
  longint m_stall    = 0;
  longint m_flush    = 0;

  initial begin
    forever begin
      bit e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold, lu;
      int e_state;
      longint e_stall, e_flush;
      @(negedge clk);
      e_state = m_waiting ? 2 : ((m_bub_left > 0) ? 1 : 0);
      {e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold} = 6'b111000;
      lu = ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (reset) begin
        {e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold} = 6'b000000;
        e_state = 0;
      end else if (mem_busy) begin
        {e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold} = 6'b000001;
      end else if (m_bub_left > 0) begin
        {e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold} = 6'b001010;
      end else if (ex_branch_taken) begin
        {e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold} = 6'b111110;
      end else if (lu) begin
        {e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold} = 6'b001010;
      end else if (id_jump) begin
        {e_pc, e_ifid, e_idex, e_iff, e_idf, e_hold} = 6'b111100;
      end
`ifdef HAZARD_STATS_EN
      e_stall = reset ? 0 : m_stall;
      e_flush = reset ? 0 : m_flush;
`else
      e_stall = 0;
      e_flush = 0;
`endif
      chk("pc_we", pc_we, e_pc);
      chk("ifid_we", ifid_we, e_ifid);
      chk("idex_we", idex_we, e_idex);
      chk("ifid_flush", ifid_flush, e_iff);
      chk("idex_flush", idex_flush, e_idf);
      chk("exmem_hold", exmem_hold, e_hold);
      chk("ctrl_state", ctrl_state, e_state);
      chk("mem_timeout", mem_timeout, reset ? 0 : m_to);
      chk("stall_cycles", stall_cycles, e_stall);
      chk("flush_events", flush_events, e_flush);
      // Advance the model to the state after the coming rising edge.
      if (reset) begin
        m_bub_left = 0; m_busy_run = 0; m_waiting = 0; m_to = 0;
        m_stall = 0; m_flush = 0;
      end else begin
        if (!e_pc) m_stall++;
        if (e_iff || e_idf) m_flush++;
        if (mem_busy) begin
          if (m_bub_left == 0) begin
            m_waiting = 1;
            m_busy_run++;
            if (m_busy_run >= TMO) m_to = 1;
          end
        end else if (m_bub_left > 0) begin
          m_bub_left--;
        end else begin
          m_waiting  = 0;
          m_busy_run = 0;
          if (!ex_branch_taken && lu) m_bub_left = LB - 1;
        end
      end
    end
  end

  task automatic drive(input bit busy, input bit emr, input logic [4:0] ert,
                       input logic [4:0] rs, input bit br, input bit jmp);
    @(posedge clk); #1;
    mem_busy = busy; ex_mem_read = emr; ex_rt = ert; id_rs = rs;
    id_rt = 5'd0; id_uses_rt = 1'b0; ex_branch_taken = br; id_jump = jmp;
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  initial begin
    settle;
    chk("reset_pc_we", pc_we, 0);
    chk("reset_state", ctrl_state, 0);
    chk("reset_hold", exmem_hold, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Load-use with two bubbles: state 0 -> 1 -> 0.
    drive(0, 1, 5'd8, 5'd8, 0, 0); settle;
    chk("lu1_pc_we", pc_we, 0); chk("lu1_ifid_we", ifid_we, 0);
    chk("lu1_idex_flush", idex_flush, 1); chk("lu1_state", ctrl_state, 0);
    drive(0, 0, 5'd0, 5'd0, 0, 0); settle;
    chk("lu2_pc_we", pc_we, 0); chk("lu2_idex_flush", idex_flush, 1);
    chk("lu2_state", ctrl_state, 1);
    drive(0, 0, 5'd0, 5'd0, 0, 0); settle;
    chk("lu3_pc_we", pc_we, 1); chk("lu3_state", ctrl_state, 0);

    // Load to r0 is not a hazard.
    drive(0, 1, 5'd0, 5'd0, 0, 0); settle;
    chk("r0_pc_we", pc_we, 1); chk("r0_ifid_we", ifid_we, 1);
    chk("r0_idex_we", idex_we, 1); chk("r0_idex_flush", idex_flush, 0);

    // Taken branch beats load-use.
    drive(0, 1, 5'd8, 5'd8, 1, 0); settle;
    chk("br_ifid_flush", ifid_flush, 1); chk("br_idex_flush", idex_flush, 1);
    chk("br_pc_we", pc_we, 1);
    drive(0, 0, 5'd0, 5'd0, 0, 0); settle;
    chk("br_after_state", ctrl_state, 0); chk("br_after_pc_we", pc_we, 1);

    // Memory busy during a load-use stall.
    drive(0, 1, 5'd3, 5'd3, 0, 0); settle;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 5'd0, 5'd0, 0, 0); settle;
      chk("lubusy_hold", exmem_hold, 1); chk("lubusy_pc_we", pc_we, 0);
      chk("lubusy_state", ctrl_state, 1);
    end
    drive(0, 0, 5'd0, 5'd0, 0, 0); settle;
    chk("lubusy_rest_state", ctrl_state, 1); chk("lubusy_rest_flush", idex_flush, 1);
    chk("lubusy_rest_pc_we", pc_we, 0); chk("lubusy_rest_hold", exmem_hold, 0);
    drive(0, 0, 5'd0, 5'd0, 0, 0); settle;
    chk("lubusy_done_state", ctrl_state, 0); chk("lubusy_done_pc_we", pc_we, 1);

    // Timeout after four busy cycles, sticky afterwards.
    for (int k = 1; k <= 6; k++) begin
      drive(1, 0, 5'd0, 5'd0, 0, 0); settle;
      chk("to_flag", mem_timeout, (k >= 5) ? 1 : 0);
      chk("to_state", ctrl_state, (k == 1) ? 0 : 2);
    end
    drive(0, 0, 5'd0, 5'd0, 0, 0); settle;
    chk("to_release_flag", mem_timeout, 1); chk("to_release_state", ctrl_state, 2);
    chk("to_release_pc_we", pc_we, 1);
    drive(0, 0, 5'd0, 5'd0, 0, 0); settle;
    chk("to_sticky", mem_timeout, 1); chk("to_run_state", ctrl_state, 0);

    // Reset pulse in the middle of a memory wait.
    drive(1, 0, 5'd0, 5'd0, 0, 0);
    drive(1, 0, 5'd0, 5'd0, 0, 0);
    @(posedge clk); #3;
    reset = 1'b1; mem_busy = 1'b0;
    #1;
    chk("rst_state", ctrl_state, 0); chk("rst_flag", mem_timeout, 0);
    chk("rst_stall", stall_cycles, 0); chk("rst_flush", flush_events, 0);
    chk("rst_pc_we", pc_we, 0); chk("rst_hold", exmem_hold, 0);
    @(posedge clk); #1 reset = 1'b0;
    drive(0, 1, 5'd5, 5'd5, 0, 0); settle;
    chk("post_rst_pc_we", pc_we, 0); chk("post_rst_state", ctrl_state, 0);

    // Randomized traffic; small register range to provoke hazards.
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #1;
      reset           = ($urandom_range(0, 99) == 0);
      mem_busy        = ($urandom_range(0, 99) < 20);
      ex_mem_read     = ($urandom_range(0, 1) == 1);
      ex_rt           = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = ($urandom_range(0, 1) == 1);
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      id_jump         = ($urandom_range(0, 99) < 15);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_busy = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0;
    repeat (3) @(posedge clk);
    settle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
